tl_ul_ram_responder: RTL

TL_UL_RAM_RESPONDER -- requirements
Module: tl_ul_ram_responder

---
 rtl/tl_ul_ram_responder.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/tl_ul_ram_responder.sv
// Single-beat TL-UL slave backed by a single-ported word RAM.
// One-entry response register with fixed one-cycle latency and full throughput.
module tl_ul_ram_responder #(
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned SOURCE_W = 10,
    parameter int unsigned DATA_W   = 32
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                a_valid_i,
    output logic                a_ready_o,
    input  logic [2:0]          a_opcode_i,
    input  logic [2:0]          a_param_i,
    input  logic [2:0]          a_size_i,
    input  logic [SOURCE_W-1:0] a_source_i,
    input  logic [ADDR_W-1:0]   a_address_i,
    input  logic [DATA_W/8-1:0] a_mask_i,
    input  logic [DATA_W-1:0]   a_data_i,
    output logic                d_valid_o,
    input  logic                d_ready_i,
    output logic [2:0]          d_opcode_o,
    output logic [2:0]          d_size_o,
    output logic [SOURCE_W-1:0] d_source_o,
    output logic [DATA_W-1:0]   d_data_o,
    output logic                d_denied_o,
    output logic                d_corrupt_o
);

    localparam int unsigned MaskW = DATA_W / 8;
    localparam int unsigned IdxW  = ADDR_W - 2;
    localparam int unsigned Words = 2 ** IdxW;

    localparam logic [2:0] OpPutFull    = 3'd0;
    localparam logic [2:0] OpPutPartial = 3'd1;
    localparam logic [2:0] OpArith      = 3'd2;
    localparam logic [2:0] OpLogical    = 3'd3;
    localparam logic [2:0] OpGet        = 3'd4;
    localparam logic [2:0] OpHint       = 3'd5;

    localparam logic [2:0] AccessAck     = 3'd0;
    localparam logic [2:0] AccessAckData = 3'd1;
    localparam logic [2:0] HintAck       = 3'd2;

    logic [DATA_W-1:0]   mem_q [Words];
    logic [DATA_W-1:0]   rdata_q;

    logic                d_valid_q, d_valid_d;
    logic [2:0]          d_opcode_q, d_opcode_d;
    logic [2:0]          d_size_q, d_size_d;
    logic [SOURCE_W-1:0] d_source_q, d_source_d;
    logic                d_denied_q, d_denied_d;
    logic                d_corrupt_q, d_corrupt_d;
    logic                d_rsel_q, d_rsel_d;

    logic                a_fire;
    logic                legal;
    logic                ram_we, ram_re;
    logic [2:0]          resp_op;
    logic                resp_den, resp_cor, resp_rsel;
    logic [IdxW-1:0]     word_idx;
    logic                unused_a_param;

    assign unused_a_param = ^a_param_i;
    assign word_idx       = a_address_i[ADDR_W-1:2];
    assign a_ready_o      = !reset_i && (!d_valid_q || d_ready_i);
    assign a_fire         = a_valid_i && a_ready_o;

    always_comb begin
        legal = 1'b0;
        case (a_size_i)
            3'd0:    legal = 1'b1;
            3'd1:    legal = (a_address_i[0] == 1'b0);
            3'd2:    legal = (a_address_i[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    // Decode of the request on the A channel; RAM strobes are qualified by a_fire.
    always_comb begin
        resp_op   = AccessAck;
        resp_den  = 1'b1;
        resp_cor  = 1'b0;
        resp_rsel = 1'b0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        case (a_opcode_i)
            OpPutFull, OpPutPartial: begin
                resp_op  = AccessAck;
                resp_den = !legal;
                ram_we   = a_fire && legal;
            end
            OpGet: begin
                resp_op   = AccessAckData;
                resp_den  = !legal;
                resp_cor  = !legal;
                resp_rsel = legal;
                ram_re    = a_fire && legal;
            end
            OpHint: begin
                resp_op  = HintAck;
                resp_den = !legal;
            end
            OpArith, OpLogical: begin
                resp_op  = AccessAckData;
                resp_den = 1'b1;
                resp_cor = 1'b1;
            end
            default: begin
                resp_op  = AccessAck;
                resp_den = 1'b1;
            end
        endcase
    end

    always_comb begin
        d_valid_d   = d_valid_q;
        d_opcode_d  = d_opcode_q;
        d_size_d    = d_size_q;
        d_source_d  = d_source_q;
        d_denied_d  = d_denied_q;
        d_corrupt_d = d_corrupt_q;
        d_rsel_d    = d_rsel_q;
        if (a_fire) begin
            d_valid_d   = 1'b1;
            d_opcode_d  = resp_op;
            d_size_d    = a_size_i;
            d_source_d  = a_source_i;
            d_denied_d  = resp_den;
            d_corrupt_d = resp_cor;
            d_rsel_d    = resp_rsel;
        end else if (d_ready_i) begin
            d_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            d_valid_q   <= 1'b0;
            d_opcode_q  <= 3'd0;
            d_size_q    <= 3'd0;
            d_source_q  <= '0;
            d_denied_q  <= 1'b0;
            d_corrupt_q <= 1'b0;
            d_rsel_q    <= 1'b0;
        end else begin
            d_valid_q   <= d_valid_d;
            d_opcode_q  <= d_opcode_d;
            d_size_q    <= d_size_d;
            d_source_q  <= d_source_d;
            d_denied_q  <= d_denied_d;
            d_corrupt_q <= d_corrupt_d;
            d_rsel_q    <= d_rsel_d;
        end
    end

    // Storage is deliberately not reset; contents survive a reset pulse.
    always_ff @(posedge clock_i) begin
        if (ram_we) begin
            for (int i = 0; i < MaskW; i++) begin
                if (a_mask_i[i]) begin
                    mem_q[word_idx][8*i +: 8] <= a_data_i[8*i +: 8];
                end
            end
        end
        if (ram_re) begin
            rdata_q <= mem_q[word_idx];
        end
    end

    // Outputs are forced to zero for the whole time reset is held.
    assign d_valid_o   = !reset_i && d_valid_q;
    assign d_opcode_o  = reset_i ? 3'd0 : d_opcode_q;
    assign d_size_o    = reset_i ? 3'd0 : d_size_q;
    assign d_source_o  = reset_i ? '0 : d_source_q;
    assign d_denied_o  = !reset_i && d_denied_q;
    assign d_corrupt_o = !reset_i && d_corrupt_q;
    assign d_data_o    = (!reset_i && d_rsel_q) ? rdata_q : '0;

endmodule
